// File: rtl/dmem_mmio.sv
// dmem_mmio: word-addressed data RAM plus LED, free-running cycle counter and TX byte FIFO
// registers, read combinationally for a single-cycle core.
module dmem_mmio #(
    parameter int RAM_WORDS  = 64,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWrite,
    input  logic [31:0] Addr,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic [7:0]  Leds,
    output logic [7:0]  TxData,
    output logic        TxValid,
    input  logic        TxReady
);
    localparam int RAW = $clog2(RAM_WORDS);
    localparam int PW  = $clog2(FIFO_DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW + 1)'(FIFO_DEPTH);

    logic [31:0]   ram_q [RAM_WORDS];
    logic [7:0]    leds_q, leds_d;
    logic [31:0]   cyc_q, cyc_d;
    logic [7:0]    fifo_q [FIFO_DEPTH];
    logic [7:0]    fifo_d [FIFO_DEPTH];
    logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [PW:0]   cnt_q, cnt_d;
    logic          ovf_q, ovf_d;
    logic          mapped, ram_sel, led_sel, cyc_sel, txd_sel, txs_sel;
    logic          full, empty, pop, push_req, push;
    logic          unused_addr;

    assign unused_addr = ^Addr[1:0];

    always_comb begin
        mapped   = Addr[31:9] == '0;
        ram_sel  = mapped && !Addr[8];
        led_sel  = mapped && Addr[8:2] == 7'h40;
        cyc_sel  = mapped && Addr[8:2] == 7'h41;
        txd_sel  = mapped && Addr[8:2] == 7'h42;
        txs_sel  = mapped && Addr[8:2] == 7'h43;
        full     = cnt_q == FULL_CNT;
        empty    = cnt_q == '0;
        pop      = !empty && TxReady;
        push_req = MemWrite && txd_sel;
        // a full FIFO still accepts a byte when the head leaves in the same cycle
        push     = push_req && (!full || pop);
        leds_d   = MemWrite && led_sel ? WriteData[7:0] : leds_q;
        cyc_d    = MemWrite && cyc_sel ? WriteData : cyc_q + 32'd1;
        ovf_d    = push_req && !push ? 1'b1 : MemWrite && txs_sel ? 1'b0 : ovf_q;
        rd_ptr_d = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
        wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        cnt_d    = cnt_q + (PW + 1)'(push) - (PW + 1)'(pop);
        fifo_d   = fifo_q;
        if (push) fifo_d[wr_ptr_q] = WriteData[7:0];
        ReadData = ram_sel ? ram_q[Addr[RAW+1:2]] :
                   led_sel ? {24'd0, leds_q} :
                   cyc_sel ? cyc_q :
                   txs_sel ? {26'd0, ovf_q, cnt_q, full, empty} : 32'd0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            leds_q   <= '0;
            cyc_q    <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
            fifo_q   <= '{default: '0};
        end else begin
            leds_q   <= leds_d;
            cyc_q    <= cyc_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            cnt_q    <= cnt_d;
            ovf_q    <= ovf_d;
            fifo_q   <= fifo_d;
        end
    end

    // RAM keeps its contents across reset
    always_ff @(posedge clk) begin
        if (MemWrite && ram_sel) ram_q[Addr[RAW+1:2]] <= WriteData;
    end

    assign Leds    = leds_q;
    assign TxValid = !empty;
    assign TxData  = fifo_q[rd_ptr_q];
endmodule

// File: tb/tb_dmem_mmio.sv
// tb_dmem_mmio: queue-based reference model feeds a scoreboard; a negedge monitor compares
// ReadData/Leds/TxValid each cycle and every popped TX byte.
module tb_dmem_mmio;
    logic        clk = 0, reset = 0, MemWrite = 0, TxReady = 0;
    logic [31:0] Addr = 0, WriteData = 0;
    logic [31:0] ReadData;
    logic [7:0]  Leds, TxData;
    logic        TxValid;

    dmem_mmio dut (
        .clk(clk), .reset(reset), .MemWrite(MemWrite), .Addr(Addr), .WriteData(WriteData),
        .ReadData(ReadData), .Leds(Leds), .TxData(TxData), .TxValid(TxValid), .TxReady(TxReady)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] rd;
        bit          chk_rd;
        logic [7:0]  leds;
        bit          txv;
        logic [7:0]  txd;
    } ent_t;

    int          checks = 0, passed = 0;
    logic [31:0] ram_m [int];
    logic [7:0]  leds_m = 0;
    logic [31:0] cyc_m = 0;
    logic [7:0]  fifo_m [$];
    bit          ovf_m = 0;
    ent_t        expq [$];
    logic [7:0]  txq [$];
    ent_t        mon_e;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    function automatic bit model_read(input logic [31:0] a, output logic [31:0] d);
        logic [31:0] w = a & ~32'h3;
        int n = fifo_m.size();
        d = 0;
        if (a >= 32'h200) return 1;
        if (w < 32'h100) begin
            if (!ram_m.exists(int'(w[7:2]))) return 0;
            d = ram_m[int'(w[7:2])];
            return 1;
        end
        case (w)
            32'h100: d = {24'd0, leds_m};
            32'h104: d = cyc_m;
            32'h10C: d = (ovf_m ? 32'h20 : 0) + n * 4 + (n == 4 ? 2 : 0) + (n == 0 ? 1 : 0);
            default: d = 0;
        endcase
        return 1;
    endfunction

    task automatic cyc(input bit we, input logic [31:0] a, input logic [31:0] wd, input bit rdy);
        ent_t e;
        logic [31:0] d, w;
        int n;
        bit pop;
        MemWrite = we; Addr = a; WriteData = wd; TxReady = rdy;
        e.a = a;
        e.chk_rd = model_read(a, d);
        e.rd = d;
        e.leds = leds_m;
        e.txv = fifo_m.size() != 0;
        e.txd = e.txv ? fifo_m[0] : 8'h00;
        expq.push_back(e);
        if (rdy && fifo_m.size() != 0) txq.push_back(fifo_m[0]);
        @(posedge clk);
        n = fifo_m.size();
        pop = rdy && n != 0;
        cyc_m = cyc_m + 1;
        w = a & ~32'h3;
        if (we && a < 32'h200) begin
            if (w < 32'h100) ram_m[int'(w[7:2])] = wd;
            else if (w == 32'h100) leds_m = wd[7:0];
            else if (w == 32'h104) cyc_m = wd;
            else if (w == 32'h108) begin
                if (n < 4 || pop) fifo_m.push_back(wd[7:0]);
                else ovf_m = 1;
            end else if (w == 32'h10C) ovf_m = 0;
        end
        if (pop) void'(fifo_m.pop_front());
        #1;
    endtask

    task automatic model_reset();
        leds_m = 0; cyc_m = 0; ovf_m = 0;
        fifo_m.delete();
    endtask

    always @(negedge clk) begin
        if (reset) begin
            if (expq.size() != 0) begin
                mon_e = expq.pop_front();
                if (mon_e.chk_rd) check($sformatf("rdata@%h", mon_e.a), ReadData, mon_e.rd);
                check("leds", {24'd0, Leds}, {24'd0, mon_e.leds});
                check("txvalid", {31'd0, TxValid}, {31'd0, mon_e.txv});
                if (mon_e.txv && !TxReady) check("txdata_hold", {24'd0, TxData}, {24'd0, mon_e.txd});
            end
            if (TxValid && TxReady) begin
                if (txq.size() == 0) begin
                    checks++;
                    $display("FAIL tx_pop: DUT popped %h, no byte expected", TxData);
                end else check("tx_pop", {24'd0, TxData}, {24'd0, txq.pop_front()});
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [31:0] a;
        Addr = 32'h104;
        #1;
        check("rst_cycle", ReadData, 32'd0);
        check("rst_txvalid", {31'd0, TxValid}, 32'd0);
        check("rst_leds", {24'd0, Leds}, 32'd0);
        repeat (2) @(posedge clk);
        #2 reset = 1;

        cyc(0, 32'h104, 0, 0);
        cyc(0, 32'h104, 0, 0);
        cyc(1, 32'h04C, 32'hDEADBEEF, 0);
        cyc(0, 32'h04C, 0, 0);
        cyc(0, 32'h04D, 0, 0);
        cyc(0, 32'h200, 0, 0);
        cyc(1, 32'h100, 32'h123456A5, 0);
        cyc(0, 32'h100, 0, 0);
        cyc(1, 32'h80000100, 32'h000000FF, 0);
        cyc(0, 32'h100, 0, 0);
        cyc(1, 32'h104, 32'hFFFFFFFE, 0);
        repeat (3) cyc(0, 32'h104, 0, 0);

        foreach (fifo_m[i]) ;
        for (int i = 1; i <= 5; i++) cyc(1, 32'h108, 32'(i * 'h11), 0);
        repeat (2) cyc(0, 32'h10C, 0, 0);
        repeat (5) cyc(0, 32'h108, 0, 1);
        cyc(0, 32'h10C, 0, 0);
        cyc(1, 32'h10C, 0, 0);
        cyc(0, 32'h10C, 0, 0);

        for (int i = 1; i <= 4; i++) cyc(1, 32'h108, 32'(i * 'h11), 0);
        cyc(1, 32'h108, 32'h66, 1);
        cyc(0, 32'h10C, 0, 0);
        repeat (5) cyc(0, 32'h10C, 0, 1);

        cyc(1, 32'h100, 32'h5A, 0);
        cyc(1, 32'h108, 32'hA1, 0);
        cyc(1, 32'h108, 32'hA2, 0);
        MemWrite = 0; TxReady = 0; Addr = 32'h10C;
        #1 reset = 0;
        #1;
        check("async_txvalid", {31'd0, TxValid}, 32'd0);
        check("async_leds", {24'd0, Leds}, 32'd0);
        check("async_txstat", ReadData, 32'h1);
        model_reset();
        repeat (2) @(posedge clk);
        #2 reset = 1;
        cyc(0, 32'h104, 0, 0);
        cyc(0, 32'h04C, 0, 0);
        cyc(0, 32'h104, 0, 0);

        for (int i = 0; i < 800; i++) begin
            case ($urandom_range(0, 4))
                0: a = $urandom_range(0, 255);
                1: a = 32'h100 + 32'($urandom_range(0, 3) * 4) + 32'($urandom_range(0, 3));
                2: a = 32'h110 + 32'($urandom_range(0, 'hEF));
                3: a = $urandom | 32'h200;
                default: a = 32'h108;
            endcase
            cyc(1'($urandom_range(0, 1)), a, $urandom, $urandom_range(0, 2) == 0);
        end
        repeat (6) cyc(0, 32'h10C, 0, 1);
        cyc(0, 32'h10C, 0, 0);
        @(negedge clk);
        check("tx_pending", txq.size(), 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
